// File: rtl/sample_block_buffer.sv
// Purpose : ping-pong sample buffer; fills one bank while the DMA reads the other, swaps per block.
// Latency : xfer_block one cycle after the final in_valid; xfer_dat one cycle after xfer_adr.
// Backpress: none; upstream is never stalled, a swap over an unread bank is flagged as overrun.
//
// Ports: wb_clk/wb_rst (sync, active-high) | en, block_len, in_valid, in_data (capture side)
//        xfer_block, xfer_adr, xfer_re, xfer_dat (DMA read side) | overrun, overrun_count (status)
// Optional feature: define SAMPLE_BUFFER_OVERRUN_EN to enable read accounting and overrun status.
module sample_block_buffer #(
    parameter int ADDR_W = 8
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              en,
    input  logic [ADDR_W:0]   block_len,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              xfer_block,
    input  logic [15:0]       xfer_adr,
    input  logic              xfer_re,
    output logic [15:0]       xfer_dat,
    output logic              overrun,
    output logic [7:0]        overrun_count
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    // Both banks live in one array; the MSB of the address selects the bank.
    logic [15:0]     mem [0:2*DEPTH-1];

    logic            wr_bank;
    logic [ADDR_W:0] wr_cnt;
    logic [ADDR_W:0] len;
    logic            accept;
    logic            swap;

    assign len    = (block_len > LEN_MAX) ? LEN_MAX : block_len;
    assign accept = ~wb_rst & en & in_valid & (len != '0);
    // ">=" rather than "==" so a block_len shrunk below the fill level swaps on the next sample.
    assign swap   = accept & (wr_cnt >= (len - 1'b1));

    // Storage carries no reset.
    always_ff @(posedge wb_clk) begin
        if (accept) begin
            mem[{wr_bank, wr_cnt[ADDR_W-1:0]}] <= in_data;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            xfer_block <= 1'b0;
            xfer_dat   <= '0;
        end else begin
            xfer_block <= swap;
            // Read bank is the complement of the pre-edge write bank.
            xfer_dat   <= mem[{~wr_bank, xfer_adr[ADDR_W-1:0]}];
            if (!en) begin
                wr_cnt <= '0;
            end else if (swap) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

`ifdef SAMPLE_BUFFER_OVERRUN_EN
    logic [ADDR_W:0] rd_cnt;
    logic            rd_busy;
    logic            unused_bits;

    assign unused_bits = ^xfer_adr[15:ADDR_W];

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rd_cnt        <= '0;
            rd_busy       <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (swap) begin
            // A swap overrides any consumer strobe in the same cycle.
            rd_cnt  <= '0;
            rd_busy <= 1'b1;
            if (rd_busy) begin
                overrun <= 1'b1;
                if (overrun_count != 8'hFF) begin
                    overrun_count <= overrun_count + 8'd1;
                end
            end
        end else if (xfer_re && rd_busy) begin
            rd_cnt <= rd_cnt + 1'b1;
            if ((rd_cnt + 1'b1) >= len) begin
                rd_busy <= 1'b0;
            end
        end
    end
`else
    logic unused_bits;

    assign unused_bits   = ^{xfer_re, xfer_adr[15:ADDR_W]};
    assign overrun       = 1'b0;
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_sample_block_buffer.sv
module tb_sample_block_buffer;

    localparam int AW = 8;
    localparam int N  = 1 << AW;
`ifdef SAMPLE_BUFFER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic          en = 1'b0;
    logic [AW:0]   block_len = '0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = '0;
    logic          xfer_block;
    logic [15:0]   xfer_adr = '0;
    logic          xfer_re = 1'b0;
    logic [15:0]   xfer_dat;
    logic          overrun;
    logic [7:0]    overrun_count;

    sample_block_buffer #(.ADDR_W(AW)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .en(en), .block_len(block_len),
        .in_valid(in_valid), .in_data(in_data), .xfer_block(xfer_block),
        .xfer_adr(xfer_adr), .xfer_re(xfer_re), .xfer_dat(xfer_dat),
        .overrun(overrun), .overrun_count(overrun_count)
    );

    always #5 wb_clk = ~wb_clk;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A block is "the samples collected so far"; when their number reaches the
    // effective length the block is published to the other bank.
    logic [15:0] bank_m  [2][N];
    bit          known_m [2][N];
    int          fill_n = 0;      // samples collected in the current block
    int          consumed = 0;    // samples consumed from the published block
    int          eff_len;
    bit          wbank_m = 0;
    bit          pending = 0;     // published block not yet fully consumed
    bit          published;
    bit          model_ok = 0;
    bit          e_blk = 0, e_ovr = 0, e_dat_k = 0;
    logic [15:0] e_dat = '0;
    int          e_cnt = 0;

    always @(posedge wb_clk) begin
        eff_len = (int'(block_len) > N) ? N : int'(block_len);
        if (wb_rst) begin
            fill_n = 0; consumed = 0; wbank_m = 0; pending = 0;
            e_blk = 0; e_ovr = 0; e_cnt = 0; e_dat = '0; e_dat_k = 1;
            model_ok = 1;
        end else begin
            e_dat_k   = known_m[!wbank_m][xfer_adr[AW-1:0]];
            e_dat     = bank_m[!wbank_m][xfer_adr[AW-1:0]];
            published = 0;
            if (!en) begin
                fill_n = 0;
            end else if (in_valid && eff_len != 0) begin
                bank_m[wbank_m][fill_n]  = in_data;
                known_m[wbank_m][fill_n] = 1;
                fill_n++;
                if (fill_n >= eff_len) published = 1;
            end
            e_blk = published;
            if (published) begin
                if (pending && OVR_EN) begin
                    e_ovr = 1;
                    if (e_cnt < 255) e_cnt++;
                end
                fill_n = 0; wbank_m = !wbank_m; pending = 1; consumed = 0;
            end else if (xfer_re && pending) begin
                consumed++;
                if (consumed >= eff_len) pending = 0;
            end
        end
    end

    always @(negedge wb_clk) begin
        if (model_ok) begin
            check("xfer_block", 32'(xfer_block), 32'(e_blk));
            check("overrun", 32'(overrun), 32'(e_ovr));
            check("overrun_count", 32'(overrun_count), 32'(e_cnt));
            if (e_dat_k) check("xfer_dat", 32'(xfer_dat), 32'(e_dat));
            if (xfer_block) pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_reset();
        wb_rst = 1'b1; en = 1'b0; in_valid = 1'b0; xfer_re = 1'b0;
        tick();
        wb_rst = 1'b0; en = 1'b1;
        pulses = 0;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume(input int n);
        xfer_re = 1'b1;
        repeat (n) tick();
        xfer_re = 1'b0;
    endtask

    task automatic read_check(input string name, input int idx, input logic [15:0] exp);
        xfer_adr = 16'(idx);
        @(posedge wb_clk);
        @(negedge wb_clk);
        check(name, 32'(xfer_dat), 32'(exp));
        #4;
    endtask

    logic [15:0] basic_vals [4];

    initial begin
        basic_vals[0] = 16'h1111; basic_vals[1] = 16'h2222;
        basic_vals[2] = 16'h3333; basic_vals[3] = 16'h4444;

        // Basic block
        #1;
        do_reset();
        check("reset_xfer_dat", 32'(xfer_dat), 32'h0);
        check("reset_overrun_count", 32'(overrun_count), 32'h0);
        block_len = 9'd4;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("basic_no_early_pulse", 32'(xfer_block), 32'h0);
            send(basic_vals[i]);
        end
        check("basic_pulse_now", 32'(xfer_block), 32'h1);
        tick(); tick();
        check("basic_pulses", 32'(pulses), 32'd1);
        for (int i = 0; i < 4; i++) read_check("basic_read", i, basic_vals[i]);

        // Ping-pong
        do_reset();
        block_len = 9'd4;
        for (int i = 1; i <= 4; i++) send(16'(i));
        consume(4);
        read_check("pp_bank0", 2, 16'd3);
        for (int i = 5; i <= 8; i++) send(16'(i));
        tick();
        check("pp_pulses", 32'(pulses), 32'd2);
        for (int i = 0; i < 4; i++) read_check("pp_bank1", i, 16'(i + 5));

        // Overrun, no consumption
        do_reset();
        block_len = 9'd4;
        for (int i = 0; i < 12; i++) send(16'(100 + i));
        tick();
        check("ovr_pulses", 32'(pulses), 32'd3);
        check("ovr_flag", 32'(overrun), OVR_EN ? 32'd1 : 32'd0);
        check("ovr_count", 32'(overrun_count), OVR_EN ? 32'd2 : 32'd0);

        // Overrun avoided by consuming each block
        do_reset();
        block_len = 9'd4;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) send(16'(200 + 4 * b + i));
            consume(4);
        end
        check("noovr_pulses", 32'(pulses), 32'd3);
        check("noovr_flag", 32'(overrun), 32'd0);

        // Enable drop discards the partial block
        do_reset();
        block_len = 9'd8;
        for (int i = 0; i < 5; i++) send(16'(16'hE000 + i));
        en = 1'b0; tick(); tick(); en = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(16'hA0 + i));
        tick();
        check("endrop_pulses", 32'(pulses), 32'd1);
        for (int i = 0; i < 8; i++) read_check("endrop_read", i, 16'(16'hA0 + i));

        // Reset mid-block
        do_reset();
        block_len = 9'd4;
        for (int i = 0; i < 3; i++) send(16'(16'h5A00 + i));
        wb_rst = 1'b1; tick(); wb_rst = 1'b0;
        check("rst_xfer_block", 32'(xfer_block), 32'h0);
        check("rst_xfer_dat", 32'(xfer_dat), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_overrun_count", 32'(overrun_count), 32'h0);
        send(16'h5A03);
        tick(); tick();
        check("rst_pulses", 32'(pulses), 32'd0);

        // block_len = 0 is idle
        do_reset();
        block_len = 9'd0;
        for (int i = 0; i < 20; i++) send(16'(i));
        tick();
        check("len0_pulses", 32'(pulses), 32'd0);

        // block_len above bank depth clamps to 256
        do_reset();
        block_len = 9'd300;
        for (int i = 0; i < 255; i++) send(16'(i));
        check("clamp_pulses_255", 32'(pulses), 32'd0);
        send(16'd255);
        tick();
        check("clamp_pulses_256", 32'(pulses), 32'd1);
        for (int i = 0; i < 256; i++) send(16'(1000 + i));
        tick();
        check("clamp_pulses_512", 32'(pulses), 32'd2);
        read_check("clamp_read_last", 255, 16'd1255);

        // Randomized traffic checked by the model every cycle
        do_reset();
        block_len = 9'd4;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(63) == 0) begin
                case ($urandom_range(5))
                    0: block_len = 9'd1;
                    1: block_len = 9'd2;
                    2: block_len = 9'd4;
                    3: block_len = 9'($urandom_range(1, 511));
                    4: block_len = 9'd0;
                    default: block_len = 9'd256;
                endcase
            end
            en       = ($urandom_range(15) != 0);
            in_valid = ($urandom_range(3) != 0);
            in_data  = 16'($urandom);
            xfer_re  = ($urandom_range(2) == 0);
            if ($urandom_range(3) == 0) xfer_adr = 16'($urandom);
            wb_rst   = ($urandom_range(499) == 0);
            tick();
        end
        wb_rst = 1'b0; in_valid = 1'b0; xfer_re = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
